// File: rtl/audio_in_conditioner.sv
// audio_in_conditioner: I2S presence/rate detection and click-free soft mute; AUDIO_DC_BLOCK_EN adds a per-channel DC blocker
module audio_in_conditioner #(
    parameter int TIMEOUT_CYC = 49152,
    parameter int RAMP_TICK   = 512,
    parameter int LOCK_CNT    = 4
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic signed [15:0] in_l,
    input  logic signed [15:0] in_r,
    input  logic               in_valid,
    output logic signed [15:0] out_l,
    output logic signed [15:0] out_r,
    output logic               out_valid,
    output logic               active,
    output logic [1:0]         rate_code
);
    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    localparam int TW = $clog2(RAMP_TICK + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {MUTED, RAMP_UP, ACTIVE, RAMP_DOWN} state_t;

    state_t             state_q;
    logic [8:0]         gain_q;
    logic [IW-1:0]      idle_q;
    logic [TW-1:0]      tick_q;
    logic [11:0]        per_q;
    logic [MW-1:0]      match_q, match_d;
    logic [1:0]         last_q, cls_d;
    logic               lost, tick, mul_v, v1_q;
    logic [8:0]         gain_inc, mul_g;
    logic signed [15:0] src_l, src_r;
    logic signed [24:0] prod_l_q, prod_r_q;

    assign lost     = idle_q == IW'(TIMEOUT_CYC);
    assign tick     = state_q == RAMP_DOWN && !in_valid && tick_q == TW'(RAMP_TICK - 1);
    assign gain_inc = gain_q == 9'd256 ? gain_q : gain_q + 9'd1;

    // Idle counter: cycles since the last stereo pair, parked at the timeout
    always_ff @(posedge clk_sys) begin
        if (reset) idle_q <= '0;
        else       idle_q <= in_valid ? '0 : lost ? idle_q : idle_q + 1'b1;
    end

    // Mute/ramp state machine: owns the gain, the ramp-down step timer and active
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= MUTED;
            gain_q  <= '0;
            tick_q  <= '0;
            active  <= 1'b0;
        end else begin
            tick_q <= state_q == RAMP_DOWN && !tick ? tick_q + 1'b1 : '0;
            active <= 1'b0;
            case (state_q)
                MUTED: if (in_valid) begin
                    gain_q  <= 9'd1;
                    state_q <= RAMP_UP;
                end
                RAMP_UP: if (in_valid) begin
                    gain_q <= gain_inc;
                    if (gain_inc == 9'd256) begin
                        state_q <= ACTIVE;
                        active  <= 1'b1;
                    end
                end else if (lost) state_q <= RAMP_DOWN;
                ACTIVE: if (lost && !in_valid) state_q <= RAMP_DOWN;
                        else active <= 1'b1;
                RAMP_DOWN: if (in_valid) begin
                    gain_q  <= gain_inc;
                    state_q <= RAMP_UP;
                end else if (tick) begin
                    gain_q <= gain_q - 9'd1;
                    if (gain_q == 9'd1) state_q <= MUTED;
                end
                default: state_q <= MUTED;
            endcase
        end
    end

    // Classify the just-finished period and extend or restart the run of equal classes
    always_comb begin
        cls_d   = per_q >= 12'd740 && per_q <= 12'd800 ? 2'd1 :
                  per_q >= 12'd540 && per_q <= 12'd575 ? 2'd2 :
                  per_q >= 12'd495 && per_q <= 12'd530 ? 2'd3 : 2'd0;
        match_d = cls_d == last_q && match_q != '0 ?
                  (match_q == MW'(LOCK_CNT) ? match_q : match_q + 1'b1) : MW'(1);
    end

    // Rate lock: the first pair after mute only starts the period counter
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            per_q     <= '0;
            match_q   <= '0;
            last_q    <= '0;
            rate_code <= '0;
        end else begin
            per_q <= in_valid ? 12'd1 : per_q == 12'hFFF ? per_q : per_q + 12'd1;
            if (in_valid && state_q != MUTED) begin
                last_q  <= cls_d;
                match_q <= match_d;
                if (match_d == MW'(LOCK_CNT)) rate_code <= cls_d;
            end else if (lost) begin
                match_q   <= '0;
                rate_code <= 2'd0;
            end
        end
    end

`ifdef AUDIO_DC_BLOCK_EN
    logic signed [15:0] dc_l_q, dc_r_q, x1_l_q, x1_r_q;
    logic signed [17:0] y1_l_q, y1_r_q;
    logic signed [19:0] y_l_d, y_r_d;
    logic [8:0]         g0_q;
    logic               v0_q;

    function automatic logic signed [17:0] sat18(input logic signed [19:0] v);
        return v > 20'sd131071 ? 18'sh1FFFF : v < -20'sd131072 ? 18'sh20000 : $signed(v[17:0]);
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [19:0] v);
        return v > 20'sd32767 ? 16'sh7FFF : v < -20'sd32768 ? 16'sh8000 : $signed(v[15:0]);
    endfunction

    assign y_l_d = 20'(in_l) - 20'(x1_l_q) + 20'(y1_l_q) - 20'(y1_l_q >>> 10);
    assign y_r_d = 20'(in_r) - 20'(x1_r_q) + 20'(y1_r_q) - 20'(y1_r_q >>> 10);

    // DC blocker: one-pole high-pass per channel; its output doubles as the held pair
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            {dc_l_q, dc_r_q, x1_l_q, x1_r_q} <= '0;
            {y1_l_q, y1_r_q}                 <= '0;
            g0_q                             <= '0;
            v0_q                             <= 1'b0;
        end else begin
            v0_q <= in_valid;
            if (in_valid) begin
                x1_l_q <= in_l;
                x1_r_q <= in_r;
                y1_l_q <= sat18(y_l_d);
                y1_r_q <= sat18(y_r_d);
                dc_l_q <= sat16(y_l_d);
                dc_r_q <= sat16(y_r_d);
                g0_q   <= gain_q;
            end else if (state_q == MUTED) begin
                {x1_l_q, x1_r_q} <= '0;
                {y1_l_q, y1_r_q} <= '0;
            end
        end
    end

    assign mul_v = v0_q || tick;
    assign mul_g = v0_q ? g0_q : gain_q - 9'd1;
    assign src_l = dc_l_q;
    assign src_r = dc_r_q;
`else
    logic signed [15:0] hold_l_q, hold_r_q;

    // Keep the last pair so the ramp-down can replay it at falling gain
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hold_l_q <= '0;
            hold_r_q <= '0;
        end else if (in_valid) begin
            hold_l_q <= in_l;
            hold_r_q <= in_r;
        end
    end

    assign mul_v = in_valid || tick;
    assign mul_g = in_valid ? gain_q : gain_q - 9'd1;
    assign src_l = in_valid ? in_l : hold_l_q;
    assign src_r = in_valid ? in_r : hold_r_q;
`endif

    // Gain stage: signed sample times non-negative 9-bit gain, registered
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            prod_l_q <= '0;
            prod_r_q <= '0;
            v1_q     <= 1'b0;
        end else begin
            v1_q <= mul_v;
            if (mul_v) begin
                prod_l_q <= 25'(src_l) * $signed({16'd0, mul_g});
                prod_r_q <= 25'(src_r) * $signed({16'd0, mul_g});
            end
        end
    end

    // Output stage: drop the 8 fractional gain bits; cannot overflow since gain <= 256
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v1_q;
            if (v1_q) begin
                out_l <= 16'(prod_l_q >>> 8);
                out_r <= 16'(prod_r_q >>> 8);
            end
        end
    end
endmodule

// File: tb/tb_audio_in_conditioner.sv
// tb_audio_in_conditioner: randomized stereo stream against a gain/rate reference model
module tb_audio_in_conditioner;
    localparam int TO = 2000;
    localparam int RT = 16;
    localparam int LK = 4;

    logic               clk_sys = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_l = '0;
    logic signed [15:0] in_r = '0;
    logic signed [15:0] out_l, out_r;
    logic               out_valid, active;
    logic [1:0]         rate_code;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mg, m_last, m_run, m_rate, last_t;
    bit m_started;

    audio_in_conditioner #(.TIMEOUT_CYC(TO), .RAMP_TICK(RT), .LOCK_CNT(LK)) dut (
        .clk_sys(clk_sys), .reset(reset), .in_l(in_l), .in_r(in_r), .in_valid(in_valid),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .active(active), .rate_code(rate_code)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int cls(input int p);
        return (p >= 740 && p <= 800) ? 1 : (p >= 540 && p <= 575) ? 2 : (p >= 495 && p <= 530) ? 3 : 0;
    endfunction

    function automatic int scale(input int x, input int g);
        return (x * g) >>> 8;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        mg = 0;
        m_last = 0;
        m_run = 0;
        m_rate = 0;
        m_started = 0;
    endtask

    // one stereo pair, checked two cycles later; per = cycles until the next pair
    task automatic send(input int l, input int r, input int per);
        int c, el, er;
        @(negedge clk_sys);
        in_valid = 1'b1;
        in_l = 16'(l);
        in_r = 16'(r);
        if (m_started) begin
            c = cls(cyc - last_t);
            m_run = (c == m_last && m_run > 0) ? (m_run < LK ? m_run + 1 : LK) : 1;
            m_last = c;
            if (m_run == LK) m_rate = c;
        end
        m_started = 1;
        last_t = cyc;
        el = scale(l, mg);
        er = scale(r, mg);
        mg = mg < 256 ? mg + 1 : 256;
        @(negedge clk_sys);
        in_valid = 1'b0;
        chk("lat1_valid", out_valid, 0);
        @(negedge clk_sys);
        chk("lat2_valid", out_valid, 1);
        chk("out_l", out_l, el);
        chk("out_r", out_r, er);
        chk("active", active, mg == 256);
        chk("rate", rate_code, m_rate);
        repeat (per - 3) @(negedge clk_sys);
    endtask

    // stop strobing, expect loss at the timeout and one replayed pair per ramp step
    task automatic ramp_down(input int hl, input int hr, input int stop_g);
        int n, prev;
        while (cyc - last_t < TO - 2) @(negedge clk_sys);
        chk("pre_lost_active", active, mg == 256);
        while (cyc - last_t < TO + 3) @(negedge clk_sys);
        m_rate = 0;
        m_run = 0;
        chk("lost_active", active, 0);
        chk("lost_rate", rate_code, m_rate);
        prev = -1;
        for (int g = mg - 1; g >= stop_g; g--) begin
            n = 0;
            do begin
                @(negedge clk_sys);
                n++;
            end while (!out_valid && n < RT + 4);
            chk("ramp_pulse", out_valid, 1);
            chk("ramp_l", out_l, scale(hl, g));
            chk("ramp_r", out_r, scale(hr, g));
            if (prev >= 0) chk("ramp_gap", cyc - prev, RT);
            prev = cyc;
            mg = g;
        end
        if (mg == 0) begin
            m_started = 0;
            n = 0;
            repeat (2 * RT) begin
                @(negedge clk_sys);
                n += int'(out_valid);
            end
            chk("muted_quiet", n, 0);
            chk("muted_active", active, 0);
        end
    endtask

    task automatic rate_run(input int p0, input int p1, input int want);
        do_reset();
        for (int i = 0; i < 7; i++) send(rnd16(), rnd16(), i % 2 ? p1 : p0);
        chk("rate_final", rate_code, want);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("rst_out_l", out_l, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_active", active, 0);
        chk("rst_rate", rate_code, 0);

        for (int k = 0; k < 290; k++)
            send(k == 1 ? -32768 : k == 128 ? 1 : (k >= 256 && k < 260) ? -32768 : rnd16(), rnd16(), 8);
        for (int k = 0; k < 8; k++) send(16384, -16384, int'($urandom_range(495, 530)));
        chk("rate48", rate_code, 3);
        chk("active_full", active, 1);
        chk("out_full", out_l, 16384);
        ramp_down(16384, -16384, 0);

        do_reset();
        repeat (256) send(16384, -16384, 8);
        ramp_down(16384, -16384, 100);
        send(16384, -16384, 8);
        chk("resume_1900", out_l, 'h1900);
        repeat (3) send(16384, -16384, 8);

        rate_run(495, 530, 3);
        rate_run(557, 558, 2);
        rate_run(768, 768, 1);
        rate_run(740, 800, 1);
        rate_run(650, 650, 0);
        rate_run(531, 494, 0);

        do_reset();
        repeat (60) send(16384, 16384, 8);
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("midrst_out_l", out_l, 0);
        chk("midrst_out_r", out_r, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_active", active, 0);
        reset = 1'b0;
        mg = 0;
        m_last = 0;
        m_run = 0;
        m_rate = 0;
        m_started = 0;
        send(16384, 16384, 8);
        send(16384, 16384, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
